// File: rtl/arb_pkg.sv
// Shared definitions for the two-master memory arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU_BUSY = 2'd1,
        VEC_BUSY = 2'd2
    } arb_state_t;

    localparam logic GNT_CPU = 1'b0;
    localparam logic GNT_VEC = 1'b1;

    localparam int VEC_BURST_MAX_DEF = 4;

endpackage

// File: rtl/vec_mem_arbiter.sv
// Merges the CPU native memory port and the vector coprocessor memory port
// onto one shared single-port memory bus. A grant is held for a whole
// transaction, and one IDLE cycle separates transactions so masters can drop
// their valid.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no transaction in flight; sample both valids and grant
// CPU_BUSY | CPU request on the bus; mem_ready is forwarded to the CPU
// VEC_BUSY | vector request on the bus; mem_ready is forwarded to the vector
module vec_mem_arbiter
    import arb_pkg::*;
#(
    parameter int VEC_BURST_MAX = VEC_BURST_MAX_DEF,
    parameter int CNT_W         = 8
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        cpu_mem_valid,
    input  logic        cpu_mem_instr,
    input  logic [31:0] cpu_mem_addr,
    input  logic [31:0] cpu_mem_wdata,
    input  logic [3:0]  cpu_mem_wstrb,
    output logic        cpu_mem_ready,
    output logic [31:0] cpu_mem_rdata,

    input  logic        vec_mem_valid,
    input  logic [31:0] vec_mem_addr,
    input  logic [31:0] vec_mem_wdata,
    input  logic [3:0]  vec_mem_wstrb,
    output logic        vec_mem_ready,
    output logic [31:0] vec_mem_rdata,

    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(VEC_BURST_MAX);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic             last_grant;
    logic [CNT_W-1:0] burst_cnt;
    logic             grant_cpu;
    logic             grant_vec;

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant decision and next state. Under contention the master that did not
    // win last time is chosen; the vector unit only wins after a CPU grant and
    // only while its burst allowance is not used up.
    always_comb begin
        state_nxt = state;
        grant_cpu = 1'b0;
        grant_vec = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_mem_valid && vec_mem_valid) begin
                    if ((last_grant == GNT_CPU) && (burst_cnt < BURST_MAX)) begin
                        grant_vec = 1'b1;
                    end else begin
                        grant_cpu = 1'b1;
                    end
                end else if (cpu_mem_valid) begin
                    grant_cpu = 1'b1;
                end else if (vec_mem_valid) begin
                    grant_vec = 1'b1;
                end
                if (grant_cpu) begin
                    state_nxt = CPU_BUSY;
                end else if (grant_vec) begin
                    state_nxt = VEC_BUSY;
                end
            end
            CPU_BUSY, VEC_BUSY: begin
                if (mem_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered memory request: captured on the grant edge, held while busy,
    // mem_valid dropped on the completion edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_valid  <= 1'b0;
            mem_instr  <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            mem_wstrb  <= 4'd0;
            last_grant <= GNT_VEC;
        end else if (grant_cpu) begin
            mem_valid <= 1'b1;
            mem_instr <= cpu_mem_instr;
            mem_addr  <= cpu_mem_addr;
            mem_wdata <= cpu_mem_wdata;
            mem_wstrb <= cpu_mem_wstrb;
        end else if (grant_vec) begin
            mem_valid <= 1'b1;
            mem_instr <= 1'b0;
            mem_addr  <= vec_mem_addr;
            mem_wdata <= vec_mem_wdata;
            mem_wstrb <= vec_mem_wstrb;
        end else if ((state != IDLE) && mem_ready) begin
            mem_valid  <= 1'b0;
            last_grant <= (state == VEC_BUSY) ? GNT_VEC : GNT_CPU;
        end
    end

    // Burst counter: vector grants issued while the CPU is waiting.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            burst_cnt <= '0;
        end else if (state == IDLE) begin
            if (grant_cpu || !cpu_mem_valid) begin
                burst_cnt <= '0;
            end else if (grant_vec && (burst_cnt < BURST_MAX)) begin
                burst_cnt <= burst_cnt + CNT_W'(1);
            end
        end
    end

    // Only the granted master sees mem_ready; a ready arriving in IDLE is dropped.
    assign cpu_mem_ready = (state == CPU_BUSY) && mem_ready;
    assign vec_mem_ready = (state == VEC_BUSY) && mem_ready;
    assign cpu_mem_rdata = mem_rdata;
    assign vec_mem_rdata = mem_rdata;

endmodule

// File: tb/tb_vec_mem_arbiter.sv
// Bench for vec_mem_arbiter: memory model, two request-queue masters, and a
// cycle-level reference of the arbitration rules checked every cycle.
module tb_vec_mem_arbiter;
    import arb_pkg::*;

    localparam int BURST_MAX = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        instr;
    } req_t;

    logic        clk;
    logic        resetn;
    logic        cpu_mem_valid, cpu_mem_instr, cpu_mem_ready;
    logic [31:0] cpu_mem_addr, cpu_mem_wdata, cpu_mem_rdata;
    logic [3:0]  cpu_mem_wstrb;
    logic        vec_mem_valid, vec_mem_ready;
    logic [31:0] vec_mem_addr, vec_mem_wdata, vec_mem_rdata;
    logic [3:0]  vec_mem_wstrb;
    logic        mem_valid, mem_instr, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    logic        mem_ready_q, inj_ready, mem_hold;
    logic [31:0] mem [int];
    logic [31:0] shadow [int];
    req_t        cpu_q[$];
    req_t        vec_q[$];
    int          log_id[$];
    int          log_cyc[$];
    logic [31:0] last_rd;
    int          cyc;
    int          vectors;
    int          miscompares;

    vec_mem_arbiter #(.VEC_BURST_MAX(BURST_MAX), .CNT_W(8)) dut (
        .clk(clk), .resetn(resetn),
        .cpu_mem_valid(cpu_mem_valid), .cpu_mem_instr(cpu_mem_instr),
        .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wdata(cpu_mem_wdata),
        .cpu_mem_wstrb(cpu_mem_wstrb), .cpu_mem_ready(cpu_mem_ready),
        .cpu_mem_rdata(cpu_mem_rdata),
        .vec_mem_valid(vec_mem_valid), .vec_mem_addr(vec_mem_addr),
        .vec_mem_wdata(vec_mem_wdata), .vec_mem_wstrb(vec_mem_wstrb),
        .vec_mem_ready(vec_mem_ready), .vec_mem_rdata(vec_mem_rdata),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int w);
        if (w == 0) return 32'h00800113;
        return 32'(w) * 32'h9E3779B1;
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'(a[11:2]);
    endfunction

    function automatic logic [31:0] mem_rd(input int w);
        return mem.exists(w) ? mem[w] : init_word(w);
    endfunction

    function automatic logic [31:0] shadow_rd(input int w);
        return shadow.exists(w) ? shadow[w] : init_word(w);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One-cycle-latency memory; mem_hold stalls it, inj_ready forces a stray ready.
    assign mem_ready = mem_ready_q | inj_ready;
    always @(posedge clk) begin
        logic [31:0] nw;
        if (!resetn) begin
            mem_ready_q <= 1'b0;
        end else if (mem_valid && !mem_ready_q && !mem_hold) begin
            nw = mem_rd(word_of(mem_addr));
            mem_rdata <= nw;
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) nw[8*b +: 8] = mem_wdata[8*b +: 8];
            mem[word_of(mem_addr)] = nw;
            mem_ready_q <= 1'b1;
        end else begin
            mem_ready_q <= 1'b0;
        end
    end

    task automatic complete(input int id, input req_t r, input logic [31:0] rd);
        logic [31:0] w;
        log_id.push_back(id);
        log_cyc.push_back(cyc);
        last_rd = rd;
        if (r.wstrb == 4'h0) begin
            check(id == 0 ? "cpu_rdata" : "vec_rdata", rd, shadow_rd(word_of(r.addr)));
        end else begin
            w = shadow_rd(word_of(r.addr));
            for (int b = 0; b < 4; b++)
                if (r.wstrb[b]) w[8*b +: 8] = r.wdata[8*b +: 8];
            shadow[word_of(r.addr)] = w;
        end
    endtask

    // Bus agent: reference model + per-cycle output checks at negedge, then
    // both masters act just after the following posedge.
    initial begin
        bit          m_ok;
        bit          m_busy;
        int          m_g, m_last, m_burst, g;
        logic        m_mv, m_instr;
        logic [31:0] m_addr, m_wdata;
        logic [3:0]  m_wstrb;
        logic        rc, rv, rs;
        logic [31:0] rdc, rdv;
        req_t        cr, vr;
        m_ok = 0; m_busy = 0; m_g = 0; m_last = 1; m_burst = 0;
        m_mv = 0; m_instr = 0; m_addr = 0; m_wdata = 0; m_wstrb = 0;
        cyc = 0;
        cpu_mem_valid = 0; cpu_mem_instr = 0; cpu_mem_addr = 0; cpu_mem_wdata = 0; cpu_mem_wstrb = 0;
        vec_mem_valid = 0; vec_mem_addr = 0; vec_mem_wdata = 0; vec_mem_wstrb = 0;
        forever begin
            @(negedge clk);
            if (m_ok) begin
                check("mem_valid", 32'(mem_valid), 32'(m_mv));
                check("mem_instr", 32'(mem_instr), 32'(m_instr));
                check("mem_addr", mem_addr, m_addr);
                check("mem_wdata", mem_wdata, m_wdata);
                check("mem_wstrb", 32'(mem_wstrb), 32'(m_wstrb));
                check("cpu_ready", 32'(cpu_mem_ready), 32'(m_busy && m_g == 0 && mem_ready));
                check("vec_ready", 32'(vec_mem_ready), 32'(m_busy && m_g == 1 && mem_ready));
                check("cpu_rdata_route", cpu_mem_rdata, mem_rdata);
                check("vec_rdata_route", vec_mem_rdata, mem_rdata);
                check("burst_cnt", 32'(dut.burst_cnt), 32'(m_burst));
            end
            if (!resetn) begin
                m_ok = 1; m_busy = 0; m_last = 1; m_burst = 0;
                m_mv = 0; m_instr = 0; m_addr = 0; m_wdata = 0; m_wstrb = 0;
            end else if (!m_busy) begin
                g = -1;
                if (cpu_mem_valid && vec_mem_valid) g = (m_last == 0) ? 1 : 0;
                else if (cpu_mem_valid) g = 0;
                else if (vec_mem_valid) g = 1;
                if (g == 0 || !cpu_mem_valid) m_burst = 0;
                else if (g == 1 && m_burst < BURST_MAX) m_burst = m_burst + 1;
                if (g >= 0) begin
                    m_busy = 1; m_g = g; m_mv = 1;
                    m_instr = (g == 0) ? cpu_mem_instr : 1'b0;
                    m_addr  = (g == 0) ? cpu_mem_addr  : vec_mem_addr;
                    m_wdata = (g == 0) ? cpu_mem_wdata : vec_mem_wdata;
                    m_wstrb = (g == 0) ? cpu_mem_wstrb : vec_mem_wstrb;
                end
            end else if (mem_ready) begin
                m_busy = 0; m_mv = 0; m_last = m_g;
            end
            rc = cpu_mem_ready; rv = vec_mem_ready; rdc = cpu_mem_rdata; rdv = vec_mem_rdata;
            rs = resetn;
            @(posedge clk);
            cyc++;
            #1;
            if (!rs) begin
                if (cpu_mem_valid) void'(cpu_q.pop_front());
                if (vec_mem_valid) void'(vec_q.pop_front());
                cpu_mem_valid = 0;
                vec_mem_valid = 0;
            end else begin
                if (cpu_mem_valid && rc) begin
                    cr = cpu_q.pop_front();
                    complete(0, cr, rdc);
                    cpu_mem_valid = 0;
                end
                if (vec_mem_valid && rv) begin
                    vr = vec_q.pop_front();
                    complete(1, vr, rdv);
                    vec_mem_valid = 0;
                end
                if (!cpu_mem_valid && cpu_q.size() != 0) begin
                    cr = cpu_q[0];
                    cpu_mem_valid = 1; cpu_mem_instr = cr.instr; cpu_mem_addr = cr.addr;
                    cpu_mem_wdata = cr.wdata; cpu_mem_wstrb = cr.wstrb;
                end
                if (!vec_mem_valid && vec_q.size() != 0) begin
                    vr = vec_q[0];
                    vec_mem_valid = 1; vec_mem_addr = vr.addr;
                    vec_mem_wdata = vr.wdata; vec_mem_wstrb = vr.wstrb;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input string tag);
        bit done;
        done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            done = (cpu_q.size() == 0) && (vec_q.size() == 0) &&
                   !cpu_mem_valid && !vec_mem_valid && !mem_valid;
        end
        check(tag, 32'(done), 32'd1);
        step();
    endtask

    function automatic req_t mk(input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] s, input logic ins);
        req_t r;
        r.addr = a; r.wdata = d; r.wstrb = s; r.instr = ins;
        return r;
    endfunction

    initial begin
        int   n0, t0, idx, who;
        bit   seen;
        req_t r;
        vectors = 0; miscompares = 0;
        resetn = 0; inj_ready = 0; mem_hold = 0;
        repeat (3) step();
        resetn = 1;
        @(negedge clk);
        check("reset_state", 32'(dut.state), 32'(IDLE));
        check("reset_mem_valid", 32'(mem_valid), 32'd0);
        step();

        // Single CPU read of word 0.
        n0 = log_id.size();
        cpu_q.push_back(mk(32'h0, 32'h0, 4'h0, 1'b0));
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = cpu_mem_valid; end
        t0 = cyc;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = mem_valid; end
        check("cpu_grant_latency", 32'(cyc - t0), 32'd1);
        wait_idle("cpu_read_done");
        check("cpu_read_count", 32'(log_id.size() - n0), 32'd1);
        check("cpu_read_data", last_rd, 32'h00800113);

        // Single vector write to byte 800.
        n0 = log_id.size();
        vec_q.push_back(mk(32'd800, 32'h000000AA, 4'hF, 1'b0));
        wait_idle("vec_write_done");
        check("vec_write_count", 32'(log_id.size() - n0), 32'd1);
        check("vec_write_mem", mem_rd(200), 32'h000000AA);

        // Contention straight after reset: alternation starting with the CPU.
        resetn = 0; step(); resetn = 1;
        n0 = log_id.size();
        for (int i = 0; i < 4; i++) begin
            cpu_q.push_back(mk(32'(300 + i) << 2, 32'h0, 4'h0, 1'b0));
            vec_q.push_back(mk(32'(400 + i) << 2, 32'h0, 4'h0, 1'b0));
        end
        wait_idle("contention_done");
        for (int i = 0; i < 8; i++)
            check($sformatf("grant_order[%0d]", i),
                  32'((log_id.size() > n0 + i) ? log_id[n0 + i] : -1), 32'(i % 2));

        // Eight strided vector loads, no CPU traffic.
        n0 = log_id.size();
        for (int i = 0; i < 8; i++) vec_q.push_back(mk(32'(400 + 4 * i), 32'h0, 4'h0, 1'b0));
        wait_idle("stride_done");
        check("stride_count", 32'(log_id.size() - n0), 32'd8);
        for (int i = 1; i < 8; i++)
            if (log_cyc.size() > n0 + i)
                check($sformatf("stride_period[%0d]", i),
                      32'(log_cyc[n0 + i] - log_cyc[n0 + i - 1]), 32'd3);
        check("stride_burst", 32'(dut.burst_cnt), 32'd0);

        // Reset while VEC_BUSY, then a stray ready.
        mem_hold = 1;
        vec_q.push_back(mk(32'd404, 32'h0, 4'h0, 1'b0));
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = mem_valid; end
        check("hold_busy", 32'(dut.state), 32'(VEC_BUSY));
        step();
        resetn = 0;
        step();
        @(negedge clk);
        check("midreset_mem_valid", 32'(mem_valid), 32'd0);
        check("midreset_state", 32'(dut.state), 32'(IDLE));
        step();
        resetn = 1; mem_hold = 0; inj_ready = 1;
        @(negedge clk);
        check("stray_cpu_ready", 32'(cpu_mem_ready), 32'd0);
        check("stray_vec_ready", 32'(vec_mem_ready), 32'd0);
        step();
        inj_ready = 0;
        wait_idle("after_reset_idle");

        // CPU fetch arriving while the vector unit streams.
        for (int i = 0; i < 6; i++) vec_q.push_back(mk(32'(1600 + 4 * i), 32'h0, 4'h0, 1'b0));
        repeat (2) step();
        cpu_q.push_back(mk(32'd1240, 32'h0, 4'h0, 1'b1));
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = cpu_mem_valid; end
        n0 = log_id.size();
        wait_idle("fetch_done");
        idx = -1;
        for (int i = n0; i < log_id.size(); i++) if (idx < 0 && log_id[i] == 0) idx = i;
        check("fetch_wait_bounded", 32'(idx >= 0 && idx - n0 <= 1), 32'd1);

        // Random mixed traffic in disjoint regions with random memory stalls.
        for (int i = 0; i < 60; i++) begin
            who = int'($urandom_range(0, 1));
            r.addr  = (32'(who != 0 ? 400 : 300) + $urandom_range(0, 99)) << 2;
            r.wstrb = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            r.wdata = $urandom;
            r.instr = (who == 0) && (r.wstrb == 4'h0) && ($urandom_range(0, 1) != 0);
            if (who != 0) vec_q.push_back(r); else cpu_q.push_back(r);
            mem_hold = ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 3)) step();
            step();
        end
        mem_hold = 0;
        wait_idle("random_done");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
